// File: rtl/full_add_pkg.sv
// rtl/full_add_pkg.sv - shared defaults for the full adder slice
package full_add_pkg;

  localparam int DEF_WIDTH   = 1;
  localparam bit DEF_REG_OUT = 1'b1;

endpackage

// File: rtl/full_add_cell.sv
// rtl/full_add_cell.sv - combinational one-bit full adder cell
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_add.sv
// rtl/full_add.sv - ripple-carry full adder with optional registered output
module full_add
  import full_add_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter bit REG_OUT = DEF_REG_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_add_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s_comb[i]),
      .co (c[i+1])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    // Reset clears the stage so an in-flight sum is dropped, never replayed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q    <= '0;
        cout_q <= 1'b0;
      end else begin
        s_q    <= s_comb;
        cout_q <= c[WIDTH];
      end
    end

    assign s    = s_q;
    assign cout = cout_q;
  end else begin : g_comb
    assign s    = s_comb;
    assign cout = c[WIDTH];
  end

endmodule

// File: tb/tb_full_add.sv
// tb/tb_full_add.sv - self-checking bench for full_add (registered, combinational, 4-bit)
module tb_full_add;

  logic       clk;
  logic       rst;
  logic       a1, b1, cin1;
  logic       s1r, c1r, s1c, c1c;
  logic [3:0] a4, b4, s4;
  logic       cin4, c4;

  int total = 0;
  int bad   = 0;

  full_add #(.WIDTH(1), .REG_OUT(1'b1)) u_w1_reg (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .s(s1r), .cout(c1r)
  );

  full_add #(.WIDTH(1), .REG_OUT(1'b0)) u_w1_comb (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .s(s1c), .cout(c1c)
  );

  full_add #(.WIDTH(4), .REG_OUT(1'b1)) u_w4_reg (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .s(s4), .cout(c4)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum, returned as {cout, s} packed into low bits.
  function automatic logic [7:0] ref_sum(input int w, input int x, input int y, input int ci);
    int t;
    t = x + y + ci;
    return 8'(t & ((1 << (w + 1)) - 1));
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] e;
  logic [3:0] va[$];
  logic [3:0] vb[$];
  logic       vc[$];

  initial begin
    rst  = 1'b1;
    a1   = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a4   = 4'h0; b4 = 4'h0; cin4 = 1'b0;

    #20;
    chk("reset_w1", {6'd0, c1r, s1r}, 8'h00);
    chk("reset_w4", {3'd0, c4, s4},   8'h00);

    @(negedge clk);
    rst = 1'b0;

    // Truth table through registered and combinational 1-bit instances.
    for (int v = 0; v <= 8; v++) begin
      if (v > 0) begin
        @(negedge clk);
        chk($sformatf("tt_reg_%0d", v - 1), {6'd0, c1r, s1r}, exp_q.pop_front());
      end
      if (v < 8) begin
        {a1, b1, cin1} = 3'(v);
        e = ref_sum(1, int'(a1), int'(b1), int'(cin1));
        exp_q.push_back(e);
        #1;
        chk($sformatf("tt_comb_%0d", v), {6'd0, c1c, s1c}, e);
      end
    end

    // Asynchronous reset between edges with all-ones operands.
    @(negedge clk);
    {a1, b1, cin1} = 3'b111;
    #10 rst = 1'b1;
    #1;
    chk("rst_async_w1", {6'd0, c1r, s1r}, 8'h00);
    chk("rst_comb_unaffected", {6'd0, c1c, s1c}, 8'h03);
    @(posedge clk);
    #1;
    chk("rst_hold_w1", {6'd0, c1r, s1r}, 8'h00);
    @(negedge clk);
    #5 rst = 1'b0;
    #1;
    chk("rst_release_noedge", {6'd0, c1r, s1r}, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_first_result", {6'd0, c1r, s1r}, 8'h03);

    // 4-bit: directed boundary vectors, then back-to-back random vectors.
    va.push_back(4'hF); vb.push_back(4'h0); vc.push_back(1'b1);
    va.push_back(4'hF); vb.push_back(4'hF); vc.push_back(1'b1);
    va.push_back(4'h5); vb.push_back(4'hA); vc.push_back(1'b0);
    for (int i = 0; i < 16; i++) begin
      va.push_back(4'($urandom_range(15)));
      vb.push_back(4'($urandom_range(15)));
      vc.push_back(1'($urandom_range(1)));
    end

    exp_q.delete();
    @(negedge clk);
    for (int i = 0; i <= 19; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk($sformatf("w4_vec_%0d", i - 1), {3'd0, c4, s4}, exp_q.pop_front());
      end
      if (i < 19) begin
        a4   = va[i];
        b4   = vb[i];
        cin4 = vc[i];
        exp_q.push_back(ref_sum(4, int'(a4), int'(b4), int'(cin4)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
